// File: rtl/booth_multiplier.sv
// Sequential signed radix-2 Booth multiplier: 2N+1 edges from load to comp, +1 per stalled cycle.
// Level-held en drives progress; en low freezes ADD/SHIFT and returns DONE to IDLE.
module booth_multiplier #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           res,
  input  logic           en,
  input  logic [N-1:0]   x,
  input  logic [N-1:0]   y,
  output logic [2*N-1:0] sol,
  output logic           comp
);

  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {IDLE, ADD, SHIFT, DONE} state_t;

  state_t          state, state_n;
  logic [N:0]      m, m_n;
  logic [N:0]      a, a_n;
  logic [N-1:0]    q, q_n;
  logic            q1, q1_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [2*N-1:0]  sol_n;
  logic [2*N+1:0]  shr;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state <= IDLE;
      m     <= '0;
      a     <= '0;
      q     <= '0;
      q1    <= 1'b0;
      cnt   <= '0;
      sol   <= '0;
    end else begin
      state <= state_n;
      m     <= m_n;
      a     <= a_n;
      q     <= q_n;
      q1    <= q1_n;
      cnt   <= cnt_n;
      sol   <= sol_n;
    end
  end

  always_comb begin
    state_n = state;
    m_n     = m;
    a_n     = a;
    q_n     = q;
    q1_n    = q1;
    cnt_n   = cnt;
    sol_n   = sol;
    // {A,Q,q1} arithmetic right shift; the old q1 falls off the end
    shr     = {a[N], a, q};

    case (state)
      IDLE: begin
        if (en) begin
          m_n     = {x[N-1], x};
          a_n     = '0;
          q_n     = y;
          q1_n    = 1'b0;
          cnt_n   = '0;
          state_n = ADD;
        end
      end
      ADD: begin
        if (en) begin
          case ({q[0], q1})
            2'b01:   a_n = a + m;
            2'b10:   a_n = a + ~m + (N+1)'(1);
            default: a_n = a;
          endcase
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (en) begin
          a_n   = shr[2*N+1:N+1];
          q_n   = shr[N:1];
          q1_n  = shr[0];
          cnt_n = cnt + CW'(1);
          if (cnt == CW'(N - 1)) begin
            sol_n   = shr[2*N:1];
            state_n = DONE;
          end else begin
            state_n = ADD;
          end
        end
      end
      DONE: begin
        if (!en) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign comp = (state == DONE);

endmodule

// File: tb/tb_booth_multiplier.sv
// Randomized and directed bench for booth_multiplier (N=8) against a plain-arithmetic product model.
module tb_booth_multiplier;

  logic        clk;
  logic        res;
  logic        en;
  logic [7:0]  x;
  logic [7:0]  y;
  logic [15:0] sol;
  logic        comp;

  int total = 0;
  int bad   = 0;

  booth_multiplier #(.N(8)) dut (
    .clk  (clk),
    .res  (res),
    .en   (en),
    .x    (x),
    .y    (y),
    .sol  (sol),
    .comp (comp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] ref_product(input logic [7:0] a, input logic [7:0] b);
    int p;
    p = $signed(a) * $signed(b);
    return p[15:0];
  endfunction

  // Called at a negedge with the DUT in IDLE. en is held low for edges st..st+sl-1.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int st, input int sl,
                        input bit scramble, input string tag);
    int          edges;
    bit          done;
    logic [15:0] prev;
    logic [15:0] exp;
    exp   = ref_product(a, b);
    prev  = sol;
    x     = a;
    y     = b;
    edges = 0;
    done  = 1'b0;
    while (!done && edges < 200) begin
      en = !((edges + 1) >= st && (edges + 1) < st + sl);
      @(negedge clk);
      edges++;
      if (scramble && edges == 1) begin
        x = 8'hFF;
        y = 8'hFF;
      end
      if (comp) done = 1'b1;
      else if (sol !== prev) check({tag, "_partial"}, 32'(sol), 32'(prev));
    end
    en = 1'b1;
    check({tag, "_latency"}, 32'(edges), 32'(17 + sl));
    check({tag, "_sol"}, 32'(sol), 32'(exp));
  endtask

  // From DONE: one edge with en low must return to IDLE keeping sol.
  task automatic go_idle(input string tag);
    logic [15:0] keep;
    keep = sol;
    en   = 1'b0;
    @(negedge clk);
    check({tag, "_comp_low"}, 32'(comp), 32'd0);
    check({tag, "_sol_kept"}, 32'(sol), 32'(keep));
  endtask

  logic [7:0] vx [8];
  logic [7:0] vy [8];

  initial begin
    vx[0] = 8'd13;  vy[0] = 8'd11;
    vx[1] = 8'hFB;  vy[1] = 8'd7;
    vx[2] = 8'h80;  vy[2] = 8'h80;
    vx[3] = 8'h80;  vy[3] = 8'h7F;
    vx[4] = 8'h7F;  vy[4] = 8'hFF;
    vx[5] = 8'h00;  vy[5] = 8'hFF;
    vx[6] = 8'hFF;  vy[6] = 8'hFF;
    vx[7] = 8'h7F;  vy[7] = 8'h7F;

    res = 1'b1;
    en  = 1'b0;
    x   = '0;
    y   = '0;
    @(negedge clk);
    check("reset_sol", 32'(sol), 32'd0);
    check("reset_comp", 32'(comp), 32'd0);
    res = 1'b0;
    @(negedge clk);

    // Basic products and extremes
    for (int i = 0; i < 8; i++) begin
      run_op(vx[i], vy[i], 0, 0, 1'b0, $sformatf("dir%0d", i));
      go_idle($sformatf("dir%0d", i));
    end
    check("const_13x11", 32'(ref_product(8'd13, 8'd11)), 32'h008F);

    // Stall three cycles from edge 6, operands scrambled after the load edge
    run_op(8'd13, 8'd11, 6, 3, 1'b1, "stall");
    check("stall_exact", 32'(sol), 32'h008F);

    // Hold DONE with en high for 5 cycles
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_comp", 32'(comp), 32'd1);
      check("hold_sol", 32'(sol), 32'h008F);
    end
    go_idle("handshake");
    run_op(8'd3, 8'd5, 0, 0, 1'b0, "reload");
    go_idle("reload");

    // Async reset mid-operation (in SHIFT after edges 4 and 8), then restart
    for (int k = 4; k <= 8; k += 4) begin
      x  = 8'hFB;
      y  = 8'd7;
      en = 1'b1;
      repeat (k) @(negedge clk);
      #2 res = 1'b1;
      #1;
      check("async_sol", 32'(sol), 32'd0);
      check("async_comp", 32'(comp), 32'd0);
      @(negedge clk);
      res = 1'b0;
      run_op(8'd3, 8'd3, 0, 0, 1'b0, "rst_restart");
      check("rst_restart_exact", 32'(sol), 32'h0009);
      go_idle("rst_restart");
    end

    // Randomized operands and stalls
    for (int i = 0; i < 40; i++) begin
      logic [7:0] ra;
      logic [7:0] rb;
      int         st;
      int         sl;
      ra = 8'($urandom);
      rb = 8'($urandom);
      st = int'($urandom_range(2, 17));
      sl = int'($urandom_range(0, 3));
      run_op(ra, rb, st, sl, ($urandom_range(0, 1) == 1), "rand");
      go_idle("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
